// File: rtl/core_pkg.sv
// Shared definitions for the branch predictor: predictor modes, the 2-bit
// saturating counter type, the sweep/run state enum and the counter step.
package core_pkg;

    localparam int PRED_STATIC  = 0;
    localparam int PRED_BIMODAL = 1;
    localparam int PRED_GSHARE  = 2;

    typedef logic [1:0] ctr_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Saturating step of a 2-bit confidence counter toward the resolved outcome.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Counter storage with its own init-sweep pointer. Two asynchronous read
// ports (decode lookup, execute read-modify-write) and one synchronous write
// port shared between the sweep and resolved-branch updates.
module bp_counter_table
    import core_pkg::*;
#(
    parameter int   IDX_BITS = 8,
    parameter ctr_t CTR_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_sweep,
    output logic                o_sweep_last,
    input  logic                i_wr_en,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  ctr_t                i_wr_data,
    input  logic [IDX_BITS-1:0] i_rd_a_idx,
    output ctr_t                o_rd_a,
    input  logic [IDX_BITS-1:0] i_rd_b_idx,
    output ctr_t                o_rd_b
);

    localparam int DEPTH = 1 << IDX_BITS;

    ctr_t                r_mem [DEPTH];
    logic [IDX_BITS-1:0] r_ptr;
    logic                w_we;
    logic [IDX_BITS-1:0] w_widx;
    ctr_t                w_wdata;

    // The sweep owns the write port while active; updates are refused upstream then.
    always_comb begin
        w_we    = i_sweep | i_wr_en;
        w_widx  = i_sweep ? r_ptr : i_wr_idx;
        w_wdata = i_sweep ? CTR_INIT : i_wr_data;
    end

    // Sweep pointer; wraps back to 0 after the last entry so a later sweep starts clean.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (i_sweep) begin
            r_ptr <= r_ptr + IDX_BITS'(1);
        end
    end

    // Table contents carry no reset; the sweep establishes them.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    assign o_sweep_last = &r_ptr;
    assign o_rd_a       = r_mem[i_rd_a_idx];
    assign o_rd_b       = r_mem[i_rd_b_idx];

endmodule

// File: rtl/branch_predictor.sv
// Conditional branch predictor: static BTFNT, bimodal or gshare.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | sweeping CTR_INIT into every entry; predictions fall back
//           | to BTFNT and resolved-branch table updates are dropped
//   ST_RUN  | table lookups drive predictions, resolves train the table
module branch_predictor
    import core_pkg::*;
#(
    parameter int         BHT_BITS = 8,
    parameter int         GHR_BITS = 8,
    parameter int         MODE     = 2,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                d_valid,
    input  logic [31:0]         d_PC,
    input  logic                d_backward,
    output logic                d_predict,
    output logic [BHT_BITS-1:0] d_index,
    input  logic                e_valid,
    input  logic [BHT_BITS-1:0] e_index,
    input  logic                e_taken,
    input  logic                e_predict,
    output logic                busy,
    output logic [31:0]         nb_branch,
    output logic [31:0]         nb_hit
);

    localparam bp_state_e RST_STATE = (MODE == PRED_STATIC) ? ST_RUN : ST_INIT;

    bp_state_e           r_state;
    logic [GHR_BITS-1:0] r_ghr;
    logic [31:0]         r_nb_branch;
    logic [31:0]         r_nb_hit;
    logic                w_sweep_last;
    ctr_t                w_pred_ctr;
    logic [BHT_BITS-1:0] w_pc_idx;
    logic [BHT_BITS-1:0] w_ghr_ext;
    logic                w_unused;

    assign w_pc_idx  = d_PC[BHT_BITS+1:2];
    assign w_ghr_ext = BHT_BITS'(r_ghr);
    assign d_index   = (MODE == PRED_GSHARE) ? (w_pc_idx ^ w_ghr_ext) : w_pc_idx;
    assign busy      = (r_state == ST_INIT);
    assign d_predict = ((MODE == PRED_STATIC) || busy) ? d_backward : w_pred_ctr[1];
    assign nb_branch = r_nb_branch;
    assign nb_hit    = r_nb_hit;

    // d_valid only qualifies the outputs for the consumer; nothing here depends on it.
    assign w_unused = ^{d_valid, d_PC[31:BHT_BITS+2], d_PC[1:0], w_pred_ctr[0], e_index};

    if (MODE != PRED_STATIC) begin : g_table
        ctr_t w_upd_cur;
        ctr_t w_upd_next;

        assign w_upd_next = ctr_next(w_upd_cur, e_taken);

        bp_counter_table #(
            .IDX_BITS (BHT_BITS),
            .CTR_INIT (CTR_INIT)
        ) u_table (
            .clk          (clk),
            .resetn       (resetn),
            .i_sweep      (busy),
            .o_sweep_last (w_sweep_last),
            .i_wr_en      (e_valid && !busy),
            .i_wr_idx     (e_index),
            .i_wr_data    (w_upd_next),
            .i_rd_a_idx   (d_index),
            .o_rd_a       (w_pred_ctr),
            .i_rd_b_idx   (e_index),
            .o_rd_b       (w_upd_cur)
        );
    end else begin : g_static
        assign w_sweep_last = 1'b1;
        assign w_pred_ctr   = '0;
    end

    // Leave INIT once the sweep has written the last entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= RST_STATE;
        end else if ((r_state == ST_INIT) && w_sweep_last) begin
            r_state <= ST_RUN;
        end
    end

    // Global history follows resolved outcomes only, in every state and mode.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ghr <= '0;
        end else if (e_valid) begin
            r_ghr <= GHR_BITS'({r_ghr, e_taken});
        end
    end

    // Resolved-branch and correct-prediction counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_nb_branch <= '0;
            r_nb_hit    <= '0;
        end else if (e_valid) begin
            r_nb_branch <= r_nb_branch + 32'd1;
            if (e_taken == e_predict) begin
                r_nb_hit <= r_nb_hit + 32'd1;
            end
        end
    end

endmodule
